// File: rtl/rr_arbiter_n_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg : shared types and helpers for the N-way round-robin arbiter
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Upper bound on requesters supported by the rotated-search mask helper.
  localparam int MAX_REQ = 64;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits [base, n) set: selects the requesters searched before the wrap-around.
  function automatic logic [MAX_REQ-1:0] prio_mask(input int n, input int base);
    logic [MAX_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((i >= base) && (i < n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_n_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational winner search, rotated from base or fixed priority
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic          rr_en,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [MAX_REQ-1:0] mask_full;
  logic [2*N-1:0]     dbl;
  int                 pos;

  // Lower half holds requests at/after base; upper half is the wrapped copy,
  // so the lowest set bit of the doubled vector is the rotated winner.
  always_comb begin
    mask_full = prio_mask(N, int'(base));
    dbl       = {req, (rr_en ? (req & mask_full[N-1:0]) : {N{1'b0}})};
    found     = |req;
    pos       = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) pos = i;
    end
    idx    = (pos >= N) ? IW'(pos - N) : IW'(pos);
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n : N-requester arbiter, registered one-hot grant, bounded tenure
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  parameter  int RR_EN    = 1,
  localparam int IW       = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int            HW       = clog2_min1(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]  owner_oh;
  logic          owner_req;
  logic          others_pending;
  logic [IW-1:0] owner_next;
  logic [IW-1:0] pick_base;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_next;
  logic          preempt;
  logic          take_new;

  always_comb begin
    owner_oh           = '0;
    owner_oh[idx_q]    = 1'b1;
    owner_req          = |(req & owner_oh);
    others_pending     = |(req & ~owner_oh);
    owner_next         = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    pick_base          = (state_q == ARB_IDLE) ? ptr_q : owner_next;
    pick_next          = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    preempt            = (MAX_HOLD != 0) && (hold_q == HOLD_SAT) && others_pending;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .base   (pick_base),
    .rr_en  (RR_EN != 0),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // The full request vector feeds the search even when preempting: with a
  // rotated base the current owner comes last, and under fixed priority the
  // owner may legitimately win again.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    take_new = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) take_new = 1'b1;
      end
      ARB_BUSY: begin
        if (!owner_req) begin
          if (pick_found) begin
            take_new = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else if (preempt) begin
          take_new = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (take_new) begin
      state_d = ARB_BUSY;
      gnt_d   = pick_oh;
      valid_d = 1'b1;
      idx_d   = pick_idx;
      hold_d  = HW'(1);
      ptr_d   = pick_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_n : directed bench over four arbiter configurations
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: N=4 MAX_HOLD=3 RR; b: N=2 MAX_HOLD=3 RR; c: N=4 MAX_HOLD=1 RR; d: N=4 unlimited fixed
  logic [3:0] req_a, gnt_a, req_c, gnt_c, req_d, gnt_d;
  logic [1:0] req_b, gnt_b;
  logic       v_a, v_b, v_c, v_d;
  logic [1:0] idx_a, idx_c, idx_d;
  logic       idx_b;

  int n_checks = 0;
  int n_err    = 0;

  rr_arbiter_n #(.N(4), .MAX_HOLD(3), .RR_EN(1)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_valid(v_a), .gnt_idx(idx_a));
  rr_arbiter_n #(.N(2), .MAX_HOLD(3), .RR_EN(1)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_valid(v_b), .gnt_idx(idx_b));
  rr_arbiter_n #(.N(4), .MAX_HOLD(1), .RR_EN(1)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_valid(v_c), .gnt_idx(idx_c));
  rr_arbiter_n #(.N(4), .MAX_HOLD(0), .RR_EN(0)) u_d (
    .clk(clk), .rst(rst), .req(req_d), .gnt(gnt_d), .gnt_valid(v_d), .gnt_idx(idx_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_gnt_a", 32'(gnt_a), 32'h0);
    chk("rst_async_valid_a", 32'(v_a), 32'h0);
    chk("rst_async_idx_a", 32'(idx_a), 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    step();
    step();
    chk("reset_gnt_a", 32'(gnt_a), 32'h0);
    chk("reset_valid_a", 32'(v_a), 32'h0);
    chk("reset_idx_a", 32'(idx_a), 32'h0);
    chk("reset_gnt_b", 32'(gnt_b), 32'h0);
    chk("reset_gnt_c", 32'(gnt_c), 32'h0);
    chk("reset_gnt_d", 32'(gnt_d), 32'h0);
    rst = 1'b0;

    // Reset in the middle of a grant, then first grant must start from ptr=0.
    req_a = 4'b0100;
    step();
    chk("t1_gnt", 32'(gnt_a), 32'h4);
    chk("t1_idx", 32'(idx_a), 32'h2);
    chk("t1_valid", 32'(v_a), 32'h1);
    pulse_reset();
    req_a = 4'b1111;
    step();
    chk("t1_post_gnt", 32'(gnt_a), 32'h1);
    chk("t1_post_idx", 32'(idx_a), 32'h0);
    chk("t1_post_valid", 32'(v_a), 32'h1);
    req_a = 4'b0000;
    step();
    chk("t1_idle_gnt", 32'(gnt_a), 32'h0);

    // Two-port handover with no idle bubble.
    req_b = 2'b01;
    step();
    chk("t2_gnt_01", 32'(gnt_b), 32'h1);
    req_b = 2'b11;
    step();
    chk("t2_gnt_11", 32'(gnt_b), 32'h1);
    req_b = 2'b10;
    step();
    chk("t2_gnt_10", 32'(gnt_b), 32'h2);
    chk("t2_idx_10", 32'(idx_b), 32'h1);
    chk("t2_valid_10", 32'(v_b), 32'h1);
    req_b = 2'b00;
    step();
    chk("t2_idle_gnt", 32'(gnt_b), 32'h0);
    chk("t2_idle_valid", 32'(v_b), 32'h0);
    chk("t2_idle_idx_held", 32'(idx_b), 32'h1);

    // MAX_HOLD=1 rotates through every requester each cycle.
    req_c = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3_rotate", 32'(gnt_c), 32'(4'b0001 << (c % 4)));
    end
    req_c = 4'b0000;
    step();
    chk("t3_idle", 32'(gnt_c), 32'h0);

    // Two requesters sharing with tenure 3, starting from a fresh pointer.
    pulse_reset();
    req_a = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      step();
      chk("t4_share", 32'(gnt_a), (c >= 3 && c < 6) ? 32'h2 : 32'h1);
      chk("t4_valid", 32'(v_a), 32'h1);
    end
    req_a = 4'b0000;
    step();
    chk("t4_idle", 32'(gnt_a), 32'h0);

    // Lone requester held past the tenure limit; ptr is 1 so search lands on 2.
    req_a = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t5_hold", 32'(gnt_a), 32'h4);
    end
    req_a = 4'b0101;
    step();
    chk("t5_preempt_sat", 32'(gnt_a), 32'h1);
    chk("t5_preempt_idx", 32'(idx_a), 32'h0);
    req_a = 4'b0100;
    step();
    chk("t5_handover", 32'(gnt_a), 32'h4);
    req_a = 4'b0000;
    step();
    chk("t5_drop_gnt", 32'(gnt_a), 32'h0);
    chk("t5_drop_valid", 32'(v_a), 32'h0);
    chk("t5_drop_idx_held", 32'(idx_a), 32'h2);

    // Fixed priority, unlimited tenure.
    req_d = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t6_hold", 32'(gnt_d), 32'h2);
    end
    req_d = 4'b1000;
    step();
    chk("t6_handover", 32'(gnt_d), 32'h8);
    chk("t6_handover_idx", 32'(idx_d), 32'h3);
    req_d = 4'b1010;
    step();
    chk("t6_no_preempt", 32'(gnt_d), 32'h8);
    req_d = 4'b0010;
    step();
    chk("t6_back", 32'(gnt_d), 32'h2);
    chk("t6_back_idx", 32'(idx_d), 32'h1);
    req_d = 4'b0000;
    step();
    chk("t6_idle", 32'(gnt_d), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
